// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: state codes, port widths
// and the single-digit BCD increment used by the score counter.
package pong_pkg;

   localparam int STATE_W = 3;
   localparam int SCORE_W = 12;
   localparam int LIVES_W = 3;
   localparam int SPEED_W = 2;
   localparam int CNT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_ATTRACT = 3'd0,
      ST_SERVE   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_MISS    = 3'd3,
      ST_OVER    = 3'd4
   } state_e;

   // Next value of one BCD digit; 9 rolls to 0, the caller handles the carry.
   function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/pong_match_ctrl_bcd.sv
// bcd_counter3: three-digit BCD score counter that saturates at 999.
// clear has priority over inc; the output is the counter register itself.
module bcd_counter3
   import pong_pkg::*;
(
   input  logic               clk25,
   input  logic               reset,
   input  logic               clear,
   input  logic               inc,
   output logic [SCORE_W-1:0] value
);

   logic [SCORE_W-1:0] value_q;
   logic [SCORE_W-1:0] value_d;
   logic [SCORE_W-1:0] inc_value;
   logic [2:0]         carry;
   logic               saturated;

   assign saturated = (value_q == 12'h999);
   assign carry[0]  = inc & ~saturated;

   // Ripple the carry through the digits, ones first.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         assign inc_value[4*gi +: 4] = carry[gi] ? bcd_digit_inc(value_q[4*gi +: 4])
                                                 : value_q[4*gi +: 4];
         if (gi < 2) begin : g_carry
            assign carry[gi+1] = carry[gi] & (value_q[4*gi +: 4] == 4'd9);
         end
      end
   endgenerate

   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else begin
         value_d = inc_value;
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: attract / serve / play / miss / over.
// Optional ball speed-up on sustained rallies is enabled with PONG_SPEEDUP_EN.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 63
) (
   input  logic               clk25,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               hit_evt,
   input  logic               miss_evt,
   output logic               ball_reset,
   output logic               freeze,
   output logic               miss_flash,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [STATE_W-1:0] state,
   output logic [SPEED_W-1:0] speed
);

   localparam logic [CNT_W-1:0]   SERVE_CNT  = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]   MISS_CNT   = CNT_W'(MISS_FRAMES);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               freeze_q, freeze_d;
   logic               ball_reset_q, ball_reset_d;
   logic               miss_flash_q, miss_flash_d;
   logic               sync1_q, sync2_q, sync3_q, start_p_q;
   logic               score_clr;
   logic               hit_acc;

   // Button synchronizer and registered rising-edge pulse.
   always_ff @(posedge clk25) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         start_p_q <= 1'b0;
      end else begin
         sync1_q   <= start_btn;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         start_p_q <= sync2_q & ~sync3_q;
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         state_q <= ST_ATTRACT;
         cnt_q   <= '0;
         lives_q <= LIVES_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lives_q <= lives_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lives_d   = lives_q;
      score_clr = 1'b0;
      hit_acc   = 1'b0;
      case (state_q)
         ST_ATTRACT, ST_OVER: begin
            if (start_p_q) begin
               state_d   = ST_SERVE;
               cnt_d     = SERVE_CNT;
               lives_d   = LIVES_INIT;
               score_clr = 1'b1;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               if (cnt_q == 8'd1) begin
                  state_d = ST_PLAY;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         ST_PLAY: begin
            // A miss in the same cycle as a hit discards the hit.
            if (miss_evt) begin
               state_d = ST_MISS;
               cnt_d   = MISS_CNT;
               lives_d = (lives_q != '0) ? lives_q - 3'd1 : lives_q;
            end else if (hit_evt) begin
               hit_acc = 1'b1;
            end
         end
         ST_MISS: begin
            if (frame_tick) begin
               if (cnt_q == 8'd1) begin
                  if (lives_q == '0) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d = ST_SERVE;
                     cnt_d   = SERVE_CNT;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_ATTRACT;
         end
      endcase
   end

   // Level outputs are decoded from the next state so they change with it.
   always_comb begin
      freeze_d     = 1'b1;
      ball_reset_d = 1'b1;
      miss_flash_d = 1'b0;
      case (state_d)
         ST_PLAY: begin
            freeze_d     = 1'b0;
            ball_reset_d = 1'b0;
         end
         ST_MISS: begin
            ball_reset_d = 1'b0;
            miss_flash_d = 1'b1;
         end
         default: begin
            freeze_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         freeze_q     <= 1'b1;
         ball_reset_q <= 1'b1;
         miss_flash_q <= 1'b0;
      end else begin
         freeze_q     <= freeze_d;
         ball_reset_q <= ball_reset_d;
         miss_flash_q <= miss_flash_d;
      end
   end

   bcd_counter3 u_score (
      .clk25 (clk25),
      .reset (reset),
      .clear (score_clr),
      .inc   (hit_acc),
      .value (score)
   );

`ifdef PONG_SPEEDUP_EN
   logic [2:0]         hit_cnt_q, hit_cnt_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               serve_entry;

   assign serve_entry = (state_d == ST_SERVE) && (state_q != ST_SERVE);

   // Every eighth accepted hit bumps the speed level, up to 3.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      speed_d   = speed_q;
      if (serve_entry) begin
         hit_cnt_d = '0;
         speed_d   = '0;
      end else if (hit_acc) begin
         hit_cnt_d = hit_cnt_q + 3'd1;
         if ((hit_cnt_q == 3'd7) && (speed_q != 2'd3)) begin
            speed_d = speed_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         hit_cnt_q <= '0;
         speed_q   <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         speed_q   <= speed_d;
      end
   end

   assign speed = speed_q;
`else
   assign speed = '0;
`endif

   assign state      = state_q;
   assign lives      = lives_q;
   assign freeze     = freeze_q;
   assign ball_reset = ball_reset_q;
   assign miss_flash = miss_flash_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed testbench for pong_match_ctrl with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_pong_match_ctrl;
   import pong_pkg::*;

`ifdef PONG_SPEEDUP_EN
   localparam bit SPD = 1'b1;
`else
   localparam bit SPD = 1'b0;
`endif

   logic         clk25      = 1'b0;
   logic         reset      = 1'b1;
   logic         frame_tick = 1'b0;
   logic         start_btn  = 1'b0;
   logic         hit_evt    = 1'b0;
   logic         miss_evt   = 1'b0;
   logic         ball_reset;
   logic         freeze;
   logic         miss_flash;
   logic [11:0]  score;
   logic [2:0]   lives;
   logic [2:0]   state;
   logic [1:0]   speed;

   int checks = 0;
   int errors = 0;

   always #20 clk25 = ~clk25;

   pong_match_ctrl #(
      .LIVES        (3),
      .SERVE_FRAMES (60),
      .MISS_FRAMES  (63)
   ) dut (
      .clk25      (clk25),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
      .hit_evt    (hit_evt),
      .miss_evt   (miss_evt),
      .ball_reset (ball_reset),
      .freeze     (freeze),
      .miss_flash (miss_flash),
      .score      (score),
      .lives      (lives),
      .state      (state),
      .speed      (speed)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic check_outs(input string tag, input int st, input int fr, input int br,
                             input int mf, input int sc, input int lv);
      check_eq({tag, ".state"},      32'(state),      32'(st));
      check_eq({tag, ".freeze"},     32'(freeze),     32'(fr));
      check_eq({tag, ".ball_reset"}, 32'(ball_reset), 32'(br));
      check_eq({tag, ".miss_flash"}, 32'(miss_flash), 32'(mf));
      check_eq({tag, ".score"},      32'(score),      32'(sc));
      check_eq({tag, ".lives"},      32'(lives),      32'(lv));
   endtask

   function automatic int exp_speed(input int level);
      return SPD ? level : 0;
   endfunction

   task automatic cyc();
      @(posedge clk25);
      #1;
   endtask

   task automatic frames(input int n);
      frame_tick = 1'b1;
      repeat (n) cyc();
      frame_tick = 1'b0;
   endtask

   task automatic hits(input int n);
      hit_evt = 1'b1;
      repeat (n) cyc();
      hit_evt = 1'b0;
   endtask

   task automatic miss_pulse();
      miss_evt = 1'b1;
      cyc();
      miss_evt = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      check_outs("reset", 0, 1, 1, 0, 'h000, 3);
      check_eq("reset.speed", 32'(speed), 32'd0);

      // start_btn: start_p after 3 edges, SERVE after the 4th
      start_btn = 1'b1;
      repeat (3) cyc();
      check_eq("start.cycle3.state", 32'(state), 32'd0);
      cyc();
      check_outs("start.cycle4", 1, 1, 1, 0, 'h000, 3);
      cyc();
      start_btn = 1'b0;

      // events outside PLAY are ignored
      hits(1);
      miss_pulse();
      check_outs("serve.ignore", 1, 1, 1, 0, 'h000, 3);

      frames(59);
      check_eq("serve.59.state", 32'(state), 32'd1);
      frames(1);
      check_outs("play", 2, 0, 0, 0, 'h000, 3);

      hits(10);
      check_eq("hits10.score", 32'(score), 32'h010);
      check_eq("hits10.speed", 32'(speed), 32'(exp_speed(1)));

      // simultaneous hit and miss: miss wins, hit discarded
      hit_evt  = 1'b1;
      miss_evt = 1'b1;
      cyc();
      hit_evt  = 1'b0;
      miss_evt = 1'b0;
      check_outs("hitmiss", 3, 1, 0, 1, 'h010, 2);

      frames(62);
      check_eq("miss.62.state", 32'(state), 32'd3);
      frames(1);
      check_outs("miss.end", 1, 1, 1, 0, 'h010, 2);
      check_eq("serve2.speed", 32'(speed), 32'd0);

      frames(60);
      check_eq("play2.state", 32'(state), 32'd2);
      hits(90);
      check_eq("hits100.score", 32'(score), 32'h100);
      check_eq("hits100.speed", 32'(speed), 32'(exp_speed(3)));
      hits(898);
      check_eq("score998", 32'(score), 32'h998);
      hits(1);
      check_eq("score999", 32'(score), 32'h999);
      hits(3);
      check_eq("score_sat", 32'(score), 32'h999);

      miss_pulse();
      check_outs("miss2", 3, 1, 0, 1, 'h999, 1);
      frames(63);
      check_eq("serve3.state", 32'(state), 32'd1);
      frames(60);
      check_eq("play3.state", 32'(state), 32'd2);
      miss_pulse();
      check_outs("miss3", 3, 1, 0, 1, 'h999, 0);
      frames(63);
      check_outs("over", 4, 1, 1, 0, 'h999, 0);
      hits(2);
      miss_pulse();
      frames(5);
      check_outs("over.hold", 4, 1, 1, 0, 'h999, 0);

      start_btn = 1'b1;
      repeat (4) cyc();
      check_outs("restart", 1, 1, 1, 0, 'h000, 3);
      start_btn = 1'b0;

      // reset mid-countdown overrides a coincident frame_tick and hit
      frames(30);
      check_eq("serve30.state", 32'(state), 32'd1);
      reset      = 1'b1;
      frame_tick = 1'b1;
      hit_evt    = 1'b1;
      cyc();
      reset      = 1'b0;
      frame_tick = 1'b0;
      hit_evt    = 1'b0;
      check_outs("midreset", 0, 1, 1, 0, 'h000, 3);
      check_eq("midreset.speed", 32'(speed), 32'd0);
      frames(100);
      check_outs("attract.idle", 0, 1, 1, 0, 'h000, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match-level sequencer for the Pong game. It sits beside `game` in the top level and runs the match state machine: attract, serve countdown, play, miss, game over. It drives the game's ball reset and freeze controls, counts paddle hits as a BCD score, and tracks remaining lives. Event inputs come from the game's collision logic, and the frame tick comes from the video timer position (xpos==0, ypos==480).

## Interface
Parameters:
- LIVES, 3: lives per match; range 1–7.
- SERVE_FRAMES, 60: frames held in SERVE before play; range 1–255.
- MISS_FRAMES, 63: frames held in MISS (red flash); range 1–255.

Ports:
- clk25  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (end of visible area).
- start_btn  in  1  asynchronous pushbutton, level.
- hit_evt  in  1  one-cycle pulse: ball bounced off paddle.
- miss_evt  in  1  one-cycle pulse: ball touched bottom border.
- ball_reset  out  1  level; game holds ball at serve position while high.
- freeze  out  1  level; game suspends ball and paddle updates while high.
- miss_flash  out  1  high in MISS; selects red screen.
- score  out  12  3-digit BCD, {hundreds, tens, ones}.
- lives  out  3  remaining lives, binary.
- state  out  3  current state code, for debug/overlay.
- speed  out  2  ball speed level (see Configuration).

## Operation
- start_btn passes through a 2-flop synchronizer, then a rising-edge detector producing `start_p`.
- Frame counter: 8 bits. It is loaded on entry to SERVE/MISS and decrements on frame_tick.
- States (codes in package):
  - ATTRACT=0: freeze=1, ball_reset=1. On start_p: score←0, lives←LIVES, cnt←SERVE_FRAMES, go to SERVE.
  - SERVE=1: freeze=1, ball_reset=1. On frame_tick with cnt==1: go to PLAY. Otherwise a frame_tick decrements cnt.
  - PLAY=2: freeze=0, ball_reset=0.
    - hit_evt: score+1 in BCD, saturating at 999.
    - miss_evt: lives−1, cnt←MISS_FRAMES, go to MISS.
    - hit_evt and miss_evt in the same cycle: miss wins and the hit is discarded.
  - MISS=3: freeze=1, miss_flash=1, ball_reset=0. On frame_tick with cnt==1: go to OVER if lives==0, else reload cnt←SERVE_FRAMES and go to SERVE.
  - OVER=4: freeze=1, ball_reset=1. score and lives are held. On start_p: new match, same actions as from ATTRACT.
  - Codes 5–7 are illegal. Next state is ATTRACT.
- hit_evt and miss_evt are ignored outside PLAY. start_p is ignored outside ATTRACT and OVER.
- Score arithmetic:
  - Ones digit 9 rolls to 0 with a carry into tens.
  - Tens rolls to 0 with a carry into hundreds.
  - At 999, a hit leaves the score at 999.
- lives never decrements below 0; the decrement happens only in PLAY, where lives ≥ 1.

## Timing
- All outputs are registered.
- Reset values: state=ATTRACT, freeze=1, ball_reset=1, miss_flash=0, score=0x000, lives=LIVES, speed=0, cnt=0.
- Reset is honoured in any state, including mid-countdown, and overrides all events in the same cycle.
- An event sampled in cycle n updates state/score/lives in cycle n+1. freeze, ball_reset and miss_flash follow the new state in that same cycle.
- start_btn to start_p: 3 cycles. State changes at cycle 4.
- SERVE lasts exactly SERVE_FRAMES frame_ticks. MISS lasts exactly MISS_FRAMES frame_ticks.
- A frame_tick that coincides with the entry cycle is not counted.

## Configuration
- PONG_SPEEDUP_EN defined:
  - A 3-bit hit counter, cleared on entry to SERVE, increments on each accepted hit_evt.
  - When it wraps 7→0, speed increments, saturating at 3.
  - speed is cleared on entry to SERVE.
- PONG_SPEEDUP_EN undefined: the hit counter is absent and speed is constant 0.

## Structure
- Shared package `pong_pkg`:
  - state code constants ST_ATTRACT … ST_OVER and state width (3).
  - SCORE_W=12, LIVES_W=3, SPEED_W=2.
- Sub-module `bcd_counter3`: 3-digit saturating BCD incrementer with clk25, reset, clear, inc inputs and a 12-bit output. It is instantiated once for score.
- The synchronizer, edge detector, frame counter and FSM stay inline.

## Test plan
- Reset, then start_btn held high 5 cycles → state=SERVE at cycle 4, score=0, lives=3. After 60 frame_ticks → state=PLAY, freeze=0, ball_reset=0.
- In PLAY, 10 hit_evt pulses → score=0x010. Preload 998, then 2 hits → 0x999, saturated.
- In PLAY, hit_evt and miss_evt in the same cycle → score unchanged, lives=2, state=MISS, miss_flash=1. After 63 frame_ticks → SERVE.
- Three misses → after the third MISS expires, state=OVER. start_btn → SERVE with score=0, lives=3.
- reset asserted during SERVE with cnt=30 → next cycle all outputs at reset values. Later frame_ticks cause no transition.
- With PONG_SPEEDUP_EN: 8 hits → speed=1; 32 hits → speed=3. After a miss and the next SERVE → speed=0. Without the macro: speed stays 0 throughout.
